// File: rtl/freq_gate_counter_pkg.sv
// Shared types and default constants for the reciprocal frequency counter.
package freq_gate_counter_pkg;

  // Default result width and 50 MHz timing constants (1 s gate, 2 s timeout)
  localparam int          CNT_W_DEF       = 32;
  localparam int unsigned GATE_CYCLES_DEF = 50_000_000;
  localparam int unsigned TIMEOUT_DEF     = 100_000_000;

  // Gate and timeout timers are always wide enough for 32-bit presets,
  // independent of the result width (saturating results may be narrow)
  localparam int TMR_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    MEASURE,
    CLOSE,
    DONE
  } state_t;

endpackage

// File: rtl/sig_edge_sync.sv
// Two-flop synchroniser for an asynchronous input followed by a
// rising-edge detector producing a single-cycle pulse.
module sig_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic sync_p0;
  logic sync_p1;
  logic sync_p2;

  // Metastability filter (p0, p1) plus the delayed copy for edge detection (p2)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  assign rise = sync_p1 & ~sync_p2;

endmodule

// File: rtl/freq_gate_counter.sv
// Equal-precision frequency counter: counts clk cycles and sig_in periods
// over a gate that opens and closes on rising edges of sig_in itself.
module freq_gate_counter
  import freq_gate_counter_pkg::*;
#(
  parameter int          CNT_W       = CNT_W_DEF,
  parameter int unsigned GATE_CYCLES = GATE_CYCLES_DEF,
  parameter int unsigned TIMEOUT     = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] cnt_std,
  output logic [CNT_W-1:0] cnt_sig
);

  // The gate timer is compared after incrementing, so the preset gate spans
  // GATE_CYCLES clk from the opening edge to entry into CLOSE
  localparam logic [TMR_W-1:0] GATE_LAST = TMR_W'(GATE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TO_LAST   = TMR_W'(TIMEOUT - 1);

  state_t             state_q;
  state_t             state_d;
  logic               sig_rise;
  logic [CNT_W-1:0]   std_cnt;
  logic [CNT_W-1:0]   sig_cnt;
  logic [TMR_W-1:0]   gate_tmr;
  logic [TMR_W-1:0]   gate_nxt;
  logic [TMR_W-1:0]   to_cnt;
  logic [CNT_W-1:0]   std_nxt;
  logic [CNT_W-1:0]   sig_nxt;
  logic               accept;
  logic               open_gate;
  logic               to_close;
  logic               fin_ok;
  logic               fin_err;

  // Counters stick at all-ones rather than wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  sig_edge_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (sig_in),
    .rise (sig_rise)
  );

  assign gate_nxt = gate_tmr + TMR_W'(1);
  assign std_nxt  = sat_inc(std_cnt);
  assign sig_nxt  = sat_inc(sig_cnt);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and single-cycle event strobes
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    open_gate = 1'b0;
    to_close  = 1'b0;
    fin_ok    = 1'b0;
    fin_err   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ARM;
        end
      end
      ARM: begin
        if (sig_rise) begin
          open_gate = 1'b1;
          state_d   = MEASURE;
        end else if (to_cnt == TO_LAST) begin
          fin_err = 1'b1;
          state_d = DONE;
        end
      end
      MEASURE: begin
        // An edge landing in this cycle is counted but cannot close the gate
        if (gate_nxt == GATE_LAST) begin
          to_close = 1'b1;
          state_d  = CLOSE;
        end
      end
      CLOSE: begin
        if (sig_rise) begin
          fin_ok  = 1'b1;
          state_d = DONE;
        end else if (to_cnt == TO_LAST) begin
          fin_err = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Measurement counters: gate/timeout timers and the two saturating counts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      std_cnt  <= '0;
      sig_cnt  <= '0;
      gate_tmr <= '0;
      to_cnt   <= '0;
    end else begin
      if (state_q == IDLE || to_close) to_cnt <= '0;
      else if (state_q == ARM || state_q == CLOSE) to_cnt <= to_cnt + TMR_W'(1);

      if (open_gate) begin
        std_cnt  <= '0;
        sig_cnt  <= '0;
        gate_tmr <= '0;
      end else if (state_q == MEASURE || state_q == CLOSE) begin
        std_cnt <= std_nxt;
        if (sig_rise) sig_cnt <= sig_nxt;
        if (state_q == MEASURE) gate_tmr <= gate_nxt;
      end
    end
  end

  // Status flags and result latch; results only change on entry to DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      cnt_std <= '0;
      cnt_sig <= '0;
    end else if (accept) begin
      busy <= 1'b1;
      done <= 1'b0;
      err  <= 1'b0;
    end else if (fin_ok) begin
      busy    <= 1'b0;
      done    <= 1'b1;
      cnt_std <= std_nxt;
      cnt_sig <= sig_nxt;
    end else if (fin_err) begin
      busy    <= 1'b0;
      done    <= 1'b1;
      err     <= 1'b1;
      cnt_std <= '0;
      cnt_sig <= '0;
    end
  end

endmodule

// File: tb/tb_freq_gate_counter.sv
// Scoreboard bench: stimulus pushes expected results, monitors pop them on
// each rising edge of done and compare counts and the error flag.
module tb_freq_gate_counter;
  import freq_gate_counter_pkg::*;

  typedef struct {
    logic [31:0] std;
    logic [31:0] sig;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        sig_in;
  logic        start;
  logic        start_s;
  logic        busy, done, err;
  logic [31:0] cnt_std, cnt_sig;
  logic        busy_s, done_s, err_s;
  logic [7:0]  cnt_std_s, cnt_sig_s;

  exp_t q_m[$];
  exp_t q_s[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_done = 0;
  int   period = 0;

  freq_gate_counter #(.CNT_W(32), .GATE_CYCLES(100), .TIMEOUT(1000)) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in), .start(start),
    .busy(busy), .done(done), .err(err), .cnt_std(cnt_std), .cnt_sig(cnt_sig)
  );

  freq_gate_counter #(.CNT_W(8), .GATE_CYCLES(300), .TIMEOUT(1000)) dut_s (
    .clk(clk), .rst(rst), .sig_in(sig_in), .start(start_s),
    .busy(busy_s), .done(done_s), .err(err_s), .cnt_std(cnt_std_s), .cnt_sig(cnt_sig_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Test signal: period in clk cycles, high for the first half; 0 holds it low
  initial begin
    int ph;
    ph = 0;
    sig_in = 1'b0;
    forever begin
      @(posedge clk);
      #3;
      if (period == 0) begin
        sig_in = 1'b0;
        ph = 0;
      end else begin
        ph = (ph + 1 >= period) ? 0 : ph + 1;
        sig_in = (ph < period / 2);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor for the 32-bit instance
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done === 1'b1 && prev !== 1'b1) begin
        n_done++;
        if (q_m.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_done: got done with empty queue, expected none");
        end else begin
          e = q_m.pop_front();
          chk("cnt_std", cnt_std, e.std);
          chk("cnt_sig", cnt_sig, e.sig);
          chk("err", {31'd0, err}, {31'd0, e.err});
        end
      end
      prev = done;
    end
  end

  // Monitor for the 8-bit saturating instance
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done_s === 1'b1 && prev !== 1'b1) begin
        if (q_s.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_done_s: got done with empty queue, expected none");
        end else begin
          e = q_s.pop_front();
          chk("sat_cnt_std", {24'd0, cnt_std_s}, e.std);
          chk("sat_cnt_sig", {24'd0, cnt_sig_s}, e.sig);
          chk("sat_err", {31'd0, err_s}, {31'd0, e.err});
        end
      end
      prev = done_s;
    end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_done(input string name, input int budget, output int cyc, output int close_cyc);
    cyc = 0;
    close_cyc = 0;
    while (done !== 1'b1 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (done !== 1'b1 && dut.state_q == CLOSE) close_cyc++;
    end
    if (done !== 1'b1) begin
      n_chk++;
      $display("FAIL %s: done=%b after %0d cycles, expected 1", name, done, budget);
    end
  endtask

  initial begin
    int cyc, ccyc, d0;
    rst = 1'b1;
    start = 1'b0;
    start_s = 1'b0;
    idle_cycles(2);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_cnt_std", cnt_std, 32'd0);
    chk("rst_cnt_sig", cnt_sig, 32'd0);
    rst = 1'b0;

    // Basic exact fit: period 10 over a 100-cycle gate
    period = 10;
    idle_cycles(30);
    pulse_start();
    q_m.push_back('{std: 32'd100, sig: 32'd10, err: 1'b0});
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    wait_done("basic_done", 2000, cyc, ccyc);
    chk("basic_close_cycles", ccyc, 32'd1);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
    idle_cycles(5);

    // Gate overshoot: period 7 forces CLOSE to wait for the next edge
    period = 7;
    idle_cycles(30);
    pulse_start();
    q_m.push_back('{std: 32'd105, sig: 32'd15, err: 1'b0});
    wait_done("overshoot_done", 2000, cyc, ccyc);
    chk("overshoot_close_cycles", ccyc, 32'd6);
    idle_cycles(5);

    // Timeout with no signal, then recovery
    period = 0;
    idle_cycles(20);
    pulse_start();
    q_m.push_back('{std: 32'd0, sig: 32'd0, err: 1'b1});
    wait_done("timeout_done", 3000, cyc, ccyc);
    chk("timeout_len_ok", {31'd0, (cyc >= 990 && cyc <= 1010)}, 32'd1);
    idle_cycles(3);
    chk("err_holds", {31'd0, err}, 32'd1);
    period = 10;
    idle_cycles(30);
    pulse_start();
    q_m.push_back('{std: 32'd100, sig: 32'd10, err: 1'b0});
    chk("err_cleared_on_start", {31'd0, err}, 32'd0);
    chk("done_cleared_on_start", {31'd0, done}, 32'd0);
    wait_done("recover_done", 2000, cyc, ccyc);
    idle_cycles(5);

    // Start pulses during MEASURE are ignored
    d0 = n_done;
    pulse_start();
    q_m.push_back('{std: 32'd100, sig: 32'd10, err: 1'b0});
    cyc = 0;
    while (dut.state_q != MEASURE && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("reached_measure", {31'd0, (dut.state_q == MEASURE)}, 32'd1);
    pulse_start();
    idle_cycles(3);
    pulse_start();
    wait_done("ignore_done", 2000, cyc, ccyc);
    idle_cycles(60);
    chk("single_done", n_done - d0, 32'd1);

    // Asynchronous reset in the middle of the gate
    pulse_start();
    cyc = 0;
    while (!(dut.state_q == MEASURE && dut.gate_tmr == 32'd50) && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    chk("reached_gate50", {31'd0, (dut.gate_tmr == 32'd50)}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_err", {31'd0, err}, 32'd0);
    chk("midrst_cnt_std", cnt_std, 32'd0);
    chk("midrst_cnt_sig", cnt_sig, 32'd0);
    chk("midrst_idle", {31'd0, (dut.state_q == IDLE)}, 32'd1);
    @(negedge clk) rst = 1'b0;
    idle_cycles(5);
    pulse_start();
    q_m.push_back('{std: 32'd100, sig: 32'd10, err: 1'b0});
    wait_done("after_rst_done", 2000, cyc, ccyc);
    idle_cycles(5);

    // Saturation on the 8-bit instance with a 300-cycle gate
    @(negedge clk) start_s = 1'b1;
    @(negedge clk) start_s = 1'b0;
    q_s.push_back('{std: 32'd255, sig: 32'd30, err: 1'b0});
    cyc = 0;
    while (done_s !== 1'b1 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    if (done_s !== 1'b1) begin
      n_chk++;
      $display("FAIL sat_done: done=%b after 2000 cycles, expected 1", done_s);
    end
    idle_cycles(5);

    chk("queue_m_drained", q_m.size(), 32'd0);
    chk("queue_s_drained", q_s.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
